// File: rtl/dff_async_clear.sv
// Parameterised D flip-flop with capture enable and asynchronous active-high clear.
// Define DFF_ASYNC_CLEAR_SCLR_EN to add the synchronous clear input sclr.
module dff_async_clear #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic [WIDTH-1:0] d,
  input  logic             rst,
  input  logic             clk,
  output logic [WIDTH-1:0] q,
  input  logic             en
`ifdef DFF_ASYNC_CLEAR_SCLR_EN
  ,
  input  logic             sclr
`endif
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Next-state selection: synchronous clear beats enable, disabled capture holds.
  always_comb begin
    q_d = q_q;
`ifdef DFF_ASYNC_CLEAR_SCLR_EN
    if (sclr) begin
      q_d = RESET_VALUE;
    end else if (en) begin
      q_d = d;
    end else begin
      q_d = q_q;
    end
`else
    if (en) begin
      q_d = d;
    end else begin
      q_d = q_q;
    end
`endif
  end

  // Storage flop; rst clears immediately and overrides any pending capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_dff_async_clear.sv
// Randomised self-checking bench for dff_async_clear: a 1-bit default instance
// and an 8-bit instance with reset value 8'hA5, checked against a flop model.
module tb_dff_async_clear;

  localparam logic [7:0] RV8 = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [0:0] d1  = 1'b0;
  logic       en1 = 1'b0;
  logic [0:0] q1;
  logic [7:0] d8  = 8'h00;
  logic       en8 = 1'b0;
  logic [7:0] q8;
`ifdef DFF_ASYNC_CLEAR_SCLR_EN
  logic       sclr8 = 1'b0;
  logic       sclr1 = 1'b0;
`endif

  // expected outputs kept by the bench
  logic [0:0] e1;
  logic [7:0] e8;

  int errors = 0;
  int checks = 0;

  dff_async_clear u_dut1 (
    .d   (d1),
    .rst (rst),
    .clk (clk),
    .q   (q1),
    .en  (en1)
`ifdef DFF_ASYNC_CLEAR_SCLR_EN
    ,
    .sclr(sclr1)
`endif
  );

  dff_async_clear #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dut8 (
    .d   (d8),
    .rst (rst),
    .clk (clk),
    .q   (q8),
    .en  (en8)
`ifdef DFF_ASYNC_CLEAR_SCLR_EN
    ,
    .sclr(sclr8)
`endif
  );

  always #5 clk = ~clk;

  // Flop behaviour for one rising edge, from the values present at that edge.
  task automatic model_edge();
    logic s1;
    logic s8;
    s1 = 1'b0;
    s8 = 1'b0;
`ifdef DFF_ASYNC_CLEAR_SCLR_EN
    s1 = sclr1;
    s8 = sclr8;
`endif
    if (rst || s1) e1 = 1'b0;
    else if (en1)  e1 = d1;
    if (rst || s8) e8 = RV8;
    else if (en8)  e8 = d8;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b1;
    e1 = 1'b0;
    e8 = RV8;
    #1;
    checks++;
    if ({q1, q8} !== {e1, e8}) begin
      errors++;
      $display("FAIL reset_async_assert q1=%b q8=%h expected q1=%b q8=%h", q1, q8, e1, e8);
    end
    for (int i = 0; i < 4; i++) begin
      d1 = i[0];
      en1 = 1'b1;
      d8 = 8'($urandom);
      en8 = 1'b1;
      tick();
      checks++;
      if ({q1, q8} !== {e1, e8}) begin
        errors++;
        $display("FAIL reset_held cyc=%0d q1=%b q8=%h expected q1=%b q8=%h", i, q1, q8, e1, e8);
      end
    end
  endtask

  task automatic test_release();
    @(negedge clk);
    #1;
    rst = 1'b0;
    d1 = 1'b1;
    en1 = 1'b1;
    d8 = 8'h3C;
    en8 = 1'b1;
    #1;
    checks++;
    if ({q1, q8} !== {1'b0, RV8}) begin
      errors++;
      $display("FAIL release_before_edge q1=%b q8=%h expected q1=0 q8=a5", q1, q8);
    end
    tick();
    checks++;
    if ({q1, q8} !== {1'b1, 8'h3C}) begin
      errors++;
      $display("FAIL release_first_edge q1=%b q8=%h expected q1=1 q8=3c", q1, q8);
    end
  endtask

  task automatic test_async_mid();
    @(negedge clk);
    #2;
    d1 = 1'b1;
    d8 = 8'h77;
    rst = 1'b1;
    e1 = 1'b0;
    e8 = RV8;
    #1;
    checks++;
    if (clk !== 1'b0 || {q1, q8} !== {1'b0, RV8}) begin
      errors++;
      $display("FAIL async_mid_cycle clk=%b q1=%b q8=%h expected clk=0 q1=0 q8=a5", clk, q1, q8);
    end
    #1;
    rst = 1'b0;
    tick();
    checks++;
    if ({q1, q8} !== {1'b1, 8'h77}) begin
      errors++;
      $display("FAIL async_discard_recover q1=%b q8=%h expected q1=1 q8=77", q1, q8);
    end
  endtask

  task automatic test_enable_toggle();
    for (int i = 0; i < 7; i++) begin
      d1 = i[0] ? 1'b0 : 1'b1;
      d8 = 8'($urandom);
      en1 = (i < 3);
      en8 = (i < 3);
      tick();
      checks++;
      if ({q1, q8} !== {e1, e8}) begin
        errors++;
        $display("FAIL enable_toggle cyc=%0d q1=%b q8=%h expected q1=%b q8=%h", i, q1, q8, e1, e8);
      end
    end
    checks++;
    if (q1 !== 1'b1) begin
      errors++;
      $display("FAIL enable_freeze q1=%b expected 1", q1);
    end
  endtask

  task automatic test_random();
    logic hold;
    for (int i = 0; i < 300; i++) begin
      d1 = 1'($urandom);
      en1 = 1'($urandom);
      d8 = 8'($urandom);
      en8 = 1'($urandom);
      hold = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        #2;
        rst = 1'b1;
        e1 = 1'b0;
        e8 = RV8;
        #1;
        checks++;
        if ({q1, q8} !== {e1, e8}) begin
          errors++;
          $display("FAIL random_async cyc=%0d q1=%b q8=%h expected q1=%b q8=%h", i, q1, q8, e1, e8);
        end
        hold = 1'($urandom);
        if (!hold) begin
          #1;
          rst = 1'b0;
        end
      end
      tick();
      checks++;
      if ({q1, q8} !== {e1, e8}) begin
        errors++;
        $display("FAIL random_edge cyc=%0d q1=%b q8=%h expected q1=%b q8=%h", i, q1, q8, e1, e8);
      end
      if (hold) rst = 1'b0;
    end
  endtask

`ifdef DFF_ASYNC_CLEAR_SCLR_EN
  task automatic test_sclr();
    d8 = 8'h3C;
    en8 = 1'b1;
    d1 = 1'b1;
    en1 = 1'b1;
    tick();
    d8 = 8'h5A;
    sclr8 = 1'b1;
    sclr1 = 1'b1;
    tick();
    checks++;
    if ({q1, q8} !== {1'b0, RV8}) begin
      errors++;
      $display("FAIL sclr_edge q1=%b q8=%h expected q1=0 q8=a5", q1, q8);
    end
    sclr8 = 1'b0;
    sclr1 = 1'b0;
    tick();
    #2;
    sclr8 = 1'b1;
    rst = 1'b1;
    e1 = 1'b0;
    e8 = RV8;
    #1;
    checks++;
    if ({q1, q8} !== {1'b0, RV8}) begin
      errors++;
      $display("FAIL sclr_with_rst q1=%b q8=%h expected q1=0 q8=a5", q1, q8);
    end
    tick();
    rst = 1'b0;
    sclr8 = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_release();
    test_async_mid();
    test_enable_toggle();
    test_random();
`ifdef DFF_ASYNC_CLEAR_SCLR_EN
    test_sclr();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dff_async_clear.md
DFF_ASYNC_CLEAR -- requirements
Module: dff_async_clear

Interface
REQ-001 Parameter: WIDTH, 1, data/register width in bits (legal range 1..64).
REQ-002 Parameter: RESET_VALUE, {WIDTH{1'b0}}, value loaded into q by reset.
REQ-003 One clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  asynchronous active-high clear.
REQ-006 Port: d  input  WIDTH  data captured on rising clk.
REQ-007 Port: en  input  1  capture enable, active-high; integrators tie to 1 for a plain DFF.
REQ-008 Port: q  output  WIDTH  registered output, driven directly from the storage flop, no combinational path from any input.
REQ-009 Port declaration order SHALL be d, rst, clk, q, then en (plus sclr when configured), so positional instantiation (d, rst, clk, q) connects correctly.

Function
REQ-010 On rising clk with rst=0 and en=1, q SHALL take d; latency one edge.
REQ-011 On rising clk with rst=0 and en=0, q SHALL hold its value.
REQ-012 When rst goes high, q SHALL become RESET_VALUE immediately, with no clock edge required.
REQ-013 While rst=1, q SHALL stay RESET_VALUE regardless of clk, d and en.
REQ-014 After rst falls, q SHALL keep RESET_VALUE until the first rising clk with rst=0; that edge applies REQ-010/011.
REQ-015 If rst is high at a rising clk edge, reset SHALL win and q = RESET_VALUE.
REQ-016 Each bit SHALL behave independently; there is no arithmetic and no width conversion.
REQ-017 Before the first reset, q is undefined; no power-on initial value is required.

Reset
REQ-018 Reset value of q SHALL be RESET_VALUE (all zeros by default).
REQ-019 Reset assertion SHALL be asynchronous and reset release synchronous; no reset synchronizer is included inside the block.
REQ-020 Reset asserted mid-operation SHALL discard any pending capture.

Configuration
REQ-021 Macro DFF_ASYNC_CLEAR_SCLR_EN: when defined, the block SHALL add port sclr (input, 1 bit, active-high synchronous clear).
REQ-022 With DFF_ASYNC_CLEAR_SCLR_EN, a rising clk with rst=0 and sclr=1 SHALL load RESET_VALUE; sclr has priority over en and d.
REQ-023 With DFF_ASYNC_CLEAR_SCLR_EN, rst SHALL keep priority over sclr.
REQ-024 Without DFF_ASYNC_CLEAR_SCLR_EN, the sclr port and its logic SHALL be absent.

Verification
REQ-025 Scenario 1: d=0, rst=1, then clk edges -> q=0 throughout.
REQ-026 Scenario 2: rst 1->0, d=1, en=1, then rising clk -> q=1 after that edge, and not before it.
REQ-027 Scenario 3: q=1 and clk=0, then rst rises mid-cycle -> q=0 at the instant rst rises, before the next edge.
REQ-028 Scenario 4: rst=0, d toggles 0/1 each cycle, en=1 for 3 cycles then en=0 -> q follows d with 1-edge delay, then freezes at its last value.
REQ-029 Scenario 5: WIDTH=8, RESET_VALUE=8'hA5, d=8'h3C -> q=8'hA5 in reset, q=8'h3C one edge after release.
REQ-030 Scenario 6 (DFF_ASYNC_CLEAR_SCLR_EN defined): q=8'h3C, sclr=1 at an edge -> q=RESET_VALUE at that edge; with rst=1 and sclr=1 -> q=RESET_VALUE asynchronously.
